fake_signal_gen: RTL and testbench

FAKE_SIGNAL_GEN -- requirements
Module: fake_signal_gen

---
 rtl/fake_signal_gen_if.sv | 27 ++
 rtl/fake_signal_gen.sv | 130 +++++++++++++
 tb/tb_fake_signal_gen.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fake_signal_gen_if.sv
// Bundle for fake_signal_gen: pulse controls and raw ADC words in, ADC words and status out.
interface fake_signal_gen_if #(
  parameter int NCHAN    = 5,
  parameter int PERIOD_W = 32
);
  logic                  USE_FAKE;
  logic [NCHAN-1:0]      CHAN_MASK;
  logic [PERIOD_W-1:0]   PERIOD;
  logic [11:0]           AMPLITUDE;
  logic [7:0]            STEP;
  logic [3:0]            TAU_SHIFT;
  logic                  FORCE;
  logic [24*NCHAN-1:0]   ADC_IN;
  logic [24*NCHAN-1:0]   ADC_OUT;
  logic                  FAKE_ACTIVE;
  logic [15:0]           PULSE_COUNT;

  modport master (
    output USE_FAKE, CHAN_MASK, PERIOD, AMPLITUDE, STEP, TAU_SHIFT, FORCE, ADC_IN,
    input  ADC_OUT, FAKE_ACTIVE, PULSE_COUNT
  );

  modport slave (
    input  USE_FAKE, CHAN_MASK, PERIOD, AMPLITUDE, STEP, TAU_SHIFT, FORCE, ADC_IN,
    output ADC_OUT, FAKE_ACTIVE, PULSE_COUNT
  );
endinterface

// File: rtl/fake_signal_gen.sv
// Synthetic ADC pulse generator: linear rise, exponential decay, substituted per channel.
// Optional FAKE_SIGNAL_NOISE_EN adds small LFSR noise to the high-gain half.
module fake_signal_gen #(
  parameter int NCHAN    = 5,
  parameter int PERIOD_W = 32,
  parameter int PEDESTAL = 200,
  parameter int LG_SHIFT = 5
) (
  input  logic              CLK,
  input  logic              RESETN,
  fake_signal_gen_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

  localparam logic [12:0] PED = 13'(PEDESTAL);

  state_t                state, state_d;
  logic [11:0]           amp, amp_d;
  logic [PERIOD_W-1:0]   cnt, cnt_d;
  logic [11:0]           amp_l;
  logic [7:0]            step_l;
  logic [3:0]            tau_l;
  logic [15:0]           pulse_count;
  logic                  start;
  logic [12:0]           rise_sum;
  logic [11:0]           decay;
  logic [11:0]           fall_amp;

  // FORCE and period expiry share one start term, so a coincidence yields a single pulse.
  assign start = (state == IDLE) &&
                 (((bus.PERIOD != '0) && (cnt >= bus.PERIOD - PERIOD_W'(1))) || bus.FORCE);

  assign rise_sum = {1'b0, amp} + {5'd0, step_l};
  assign decay    = ((amp >> tau_l) == 12'd0) ? 12'd1 : (amp >> tau_l);
  assign fall_amp = (amp > decay) ? amp - decay : 12'd0;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    state_d = state;
    amp_d   = amp;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        cnt_d = cnt + PERIOD_W'(1);
        if (start) begin
          state_d = RISE;
          cnt_d   = '0;
        end
      end
      RISE: begin
        if (rise_sum >= {1'b0, amp_l}) begin
          amp_d   = amp_l;
          state_d = FALL;
        end else begin
          amp_d = rise_sum[11:0];
        end
      end
      FALL: begin
        amp_d = fall_amp;
        if (fall_amp == 12'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!RESETN) begin
      state       <= IDLE;
      amp         <= '0;
      cnt         <= '0;
      pulse_count <= '0;
      amp_l       <= '0;
      step_l      <= 8'd1;
      tau_l       <= 4'd1;
    end else begin
      state <= state_d;
      amp   <= amp_d;
      cnt   <= cnt_d;
      if (start) begin
        pulse_count <= pulse_count + 16'd1;
        amp_l       <= bus.AMPLITUDE;
        step_l      <= (bus.STEP == 8'd0) ? 8'd1 : bus.STEP;
        tau_l       <= (bus.TAU_SHIFT == 4'd0) ? 4'd1 : bus.TAU_SHIFT;
      end
    end
  end

  logic [12:0] hg_sum, lg_sum;
  logic [11:0] hg_clean, hg, lg;

  assign hg_sum   = PED + {1'b0, amp};
  assign hg_clean = hg_sum[12] ? 12'hFFF : hg_sum[11:0];
  assign lg_sum   = PED + {1'b0, amp >> LG_SHIFT};
  assign lg       = lg_sum[12] ? 12'hFFF : lg_sum[11:0];

`ifdef FAKE_SIGNAL_NOISE_EN
  logic [15:0]        lfsr;
  logic signed [13:0] hg_noisy;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Noise span is -4..+3 around the clean high-gain value.
  assign hg_noisy = $signed({2'b00, hg_clean}) + $signed({11'd0, lfsr[2:0]}) - 14'sd4;
  assign hg = (hg_noisy < 14'sd0)    ? 12'd0  :
              (hg_noisy > 14'sd4095) ? 12'hFFF : hg_noisy[11:0];
`else
  assign hg = hg_clean;
`endif

  logic [24*NCHAN-1:0] adc_out_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      adc_out_q <= '0;
    end else begin
      for (int k = 0; k < NCHAN; k++) begin
        adc_out_q[24*k +: 24] <= (bus.USE_FAKE && bus.CHAN_MASK[k]) ? {hg, lg}
                                                                    : bus.ADC_IN[24*k +: 24];
      end
    end
  end

  assign bus.ADC_OUT     = adc_out_q;
  assign bus.FAKE_ACTIVE = (state != IDLE);
  assign bus.PULSE_COUNT = pulse_count;
endmodule

// File: tb/tb_fake_signal_gen.sv
// Self-checking bench for fake_signal_gen: cycle scoreboard plus directed pulse-shape checks.
module tb_fake_signal_gen;
  localparam int NCHAN    = 5;
  localparam int PERIOD_W = 32;
  localparam int PEDESTAL = 200;
  localparam int LG_SHIFT = 5;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  fake_signal_gen_if #(.NCHAN(NCHAN), .PERIOD_W(PERIOD_W)) bus ();

  fake_signal_gen #(
    .NCHAN(NCHAN), .PERIOD_W(PERIOD_W), .PEDESTAL(PEDESTAL), .LG_SHIFT(LG_SHIFT)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .bus(bus)
  );

  typedef struct {
    logic [24*NCHAN-1:0] adc_out;
    logic                fake_active;
    logic [15:0]         pulse_count;
  } exp_t;

  typedef enum int {M_IDLE, M_RISE, M_FALL} mstate_t;

  exp_t    sb[$];
  int      hg_log[$];
  int      lg_log[$];
  int      hg_max;
  int      n_cmp = 0;
  int      n_bad = 0;
  int      n_pulses = 0;

  mstate_t m_state;
  int      m_amp, m_amp_l, m_step_l, m_tau_l, m_count;
  longint  m_cnt;
`ifdef FAKE_SIGNAL_NOISE_EN
  logic [15:0] m_lfsr;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int out_hg(input int k);
    return int'(bus.ADC_OUT[24*k+12 +: 12]);
  endfunction

  function automatic int out_lg(input int k);
    return int'(bus.ADC_OUT[24*k +: 12]);
  endfunction

  // Fake word straight from the output formulas: clamped pedestal + amplitude halves.
  function automatic logic [23:0] fake_word(input int amp, input int noise);
    int hg, lg;
    hg = PEDESTAL + amp;
    if (hg > 4095) hg = 4095;
    hg = hg + noise;
    if (hg < 0) hg = 0;
    if (hg > 4095) hg = 4095;
    lg = PEDESTAL + (amp >> LG_SHIFT);
    if (lg > 4095) lg = 4095;
    return {hg[11:0], lg[11:0]};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_amp = 0; m_cnt = 0; m_count = 0;
    m_amp_l = 0; m_step_l = 1; m_tau_l = 1;
`ifdef FAKE_SIGNAL_NOISE_EN
    m_lfsr = 16'hACE1;
`endif
    sb.delete();
  endtask

  // Predicts the outputs after the coming rising edge from the inputs now on the bus.
  task automatic model_step();
    exp_t e;
    int   noise = 0;
    int   d;
`ifdef FAKE_SIGNAL_NOISE_EN
    noise  = int'(m_lfsr[2:0]) - 4;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    for (int k = 0; k < NCHAN; k++)
      e.adc_out[24*k +: 24] = (bus.USE_FAKE && bus.CHAN_MASK[k]) ? fake_word(m_amp, noise)
                                                                 : bus.ADC_IN[24*k +: 24];
    case (m_state)
      M_IDLE: begin
        if ((bus.PERIOD != 0 && m_cnt + 1 >= longint'(bus.PERIOD)) || bus.FORCE) begin
          m_state  = M_RISE;
          m_cnt    = 0;
          m_count  = (m_count + 1) % 65536;
          m_amp_l  = int'(bus.AMPLITUDE);
          m_step_l = (bus.STEP == 0) ? 1 : int'(bus.STEP);
          m_tau_l  = (bus.TAU_SHIFT == 0) ? 1 : int'(bus.TAU_SHIFT);
        end else begin
          m_cnt++;
        end
      end
      M_RISE: begin
        if (m_amp + m_step_l >= m_amp_l) begin
          m_amp = m_amp_l;
          m_state = M_FALL;
        end else begin
          m_amp = m_amp + m_step_l;
        end
      end
      default: begin
        d = m_amp >> m_tau_l;
        if (d < 1) d = 1;
        m_amp = (m_amp > d) ? m_amp - d : 0;
        if (m_amp == 0) m_state = M_IDLE;
      end
    endcase
    e.fake_active = (m_state != M_IDLE);
    e.pulse_count = 16'(m_count);
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    for (int k = 0; k < NCHAN; k++) bus.ADC_IN[24*k +: 24] = 24'($urandom);
    model_step();
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("adc_out", bus.ADC_OUT, e.adc_out);
    check("fake_active", bus.FAKE_ACTIVE, e.fake_active);
    check("pulse_count", bus.PULSE_COUNT, e.pulse_count);
    hg_log.push_back(out_hg(0));
    lg_log.push_back(out_lg(0));
    if (out_hg(0) > hg_max) hg_max = out_hg(0);
  endtask

  task automatic wait_active(input logic want, input int budget, output int n);
    n = 0;
    while (bus.FAKE_ACTIVE !== want && n < budget) begin
      cycle();
      n++;
    end
    check("wait_active", bus.FAKE_ACTIVE, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pk;
    int exp_ramp[4] = '{225, 250, 275, 300};

    bus.USE_FAKE = 1'b0; bus.CHAN_MASK = '0; bus.PERIOD = '0; bus.AMPLITUDE = '0;
    bus.STEP = '0; bus.TAU_SHIFT = '0; bus.FORCE = 1'b0; bus.ADC_IN = '0;
    model_reset();
    hg_max = 0;

    // Reset state
    #23;
    check("rst_adc_out", bus.ADC_OUT, '0);
    check("rst_active", bus.FAKE_ACTIVE, 1'b0);
    check("rst_count", bus.PULSE_COUNT, 16'd0);
    @(posedge CLK); #1;
    RESETN = 1'b1;

    // Forced pulse on channels 0 and 2, others pass through
    bus.USE_FAKE = 1'b1; bus.CHAN_MASK = 5'b00101; bus.PERIOD = '0;
    bus.AMPLITUDE = 12'd100; bus.STEP = 8'd25; bus.TAU_SHIFT = 4'd2;
    cycle(); cycle();
    bus.FORCE = 1'b1; cycle(); bus.FORCE = 1'b0; n_pulses++;
    check("b_active", bus.FAKE_ACTIVE, 1'b1);
    cycle();
    check("b_hg_base", out_hg(0), 200);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("b_hg_ch0", out_hg(0), exp_ramp[i]);
      check("b_hg_ch2", out_hg(2), exp_ramp[i]);
    end
    bus.USE_FAKE = 1'b0; cycle(); cycle();
    bus.CHAN_MASK = 5'b11010; bus.USE_FAKE = 1'b1; cycle();
    wait_active(1'b0, 100, n);
    check("b_count", bus.PULSE_COUNT, 16'(n_pulses));

    // Peak / first decay / return to pedestal
    bus.CHAN_MASK = 5'b11111;
    bus.AMPLITUDE = 12'd1000; bus.STEP = 8'd255; bus.TAU_SHIFT = 4'd3;
    hg_log.delete(); lg_log.delete(); hg_max = 0;
    bus.FORCE = 1'b1; cycle(); bus.FORCE = 1'b0; n_pulses++;
    wait_active(1'b0, 200, n);
    cycle(); cycle();
    pk = 0;
    for (int i = 0; i < hg_log.size(); i++) if (hg_log[i] == hg_max) begin pk = i; break; end
    check("c_peak_hg", hg_max, 1200);
    check("c_peak_lg", lg_log[pk], 231);
    check("c_first_fall", (pk + 1 < hg_log.size()) ? hg_log[pk+1] : -1, 1075);
    check("c_rest_hg", out_hg(0), 200);
    check("c_rest_active", bus.FAKE_ACTIVE, 1'b0);

    // Zero amplitude: one RISE cycle, one FALL cycle
    bus.AMPLITUDE = 12'd0; bus.STEP = 8'd0; bus.TAU_SHIFT = 4'd0;
    bus.FORCE = 1'b1; cycle(); bus.FORCE = 1'b0; n_pulses++;
    check("z_rise", bus.FAKE_ACTIVE, 1'b1);
    cycle();
    check("z_fall", bus.FAKE_ACTIVE, 1'b1);
    cycle();
    check("z_idle", bus.FAKE_ACTIVE, 1'b0);
    check("z_hg", out_hg(0), 200);

    // STEP=0 and TAU_SHIFT=0 act as 1
    bus.AMPLITUDE = 12'd5;
    bus.FORCE = 1'b1; cycle(); bus.FORCE = 1'b0; n_pulses++;
    wait_active(1'b0, 50, n);

    // Shrinking PERIOD below the elapsed idle count starts a pulse at once
    bus.AMPLITUDE = 12'd300; bus.STEP = 8'd100; bus.TAU_SHIFT = 4'd1;
    repeat (30) cycle();
    bus.PERIOD = 10; cycle(); n_pulses++;
    check("g_period_shrink", bus.FAKE_ACTIVE, 1'b1);
    bus.PERIOD = 0;
    wait_active(1'b0, 100, n);

    // Saturation, FORCE held, periodic starts, FORCE coinciding with expiry
    bus.AMPLITUDE = 12'd4000; bus.STEP = 8'd200; bus.TAU_SHIFT = 4'd4;
    hg_max = 0;
    bus.FORCE = 1'b1; cycle(); n_pulses++;
    repeat (5) cycle();
    check("d_force_held", bus.PULSE_COUNT, 16'(n_pulses));
    bus.FORCE = 1'b0;
    wait_active(1'b0, 400, n);
    check("d_sat_hg", hg_max, 4095);
    bus.PERIOD = 50;
    for (int p = 0; p < 2; p++) begin
      wait_active(1'b1, 200, n); n_pulses++;
      check("d_idle_gap", n, 50);
      check("d_count", bus.PULSE_COUNT, 16'(n_pulses));
      wait_active(1'b0, 400, n);
    end
    n = 0;
    while (!bus.FAKE_ACTIVE && n < 200) begin
      bus.FORCE = (m_cnt == 49);
      cycle();
      n++;
    end
    bus.FORCE = 1'b0; n_pulses++;
    check("d_coincide_gap", n, 50);
    check("d_coincide_count", bus.PULSE_COUNT, 16'(n_pulses));
    cycle();
    check("d_coincide_single", bus.PULSE_COUNT, 16'(n_pulses));
    bus.PERIOD = 0;
    wait_active(1'b0, 400, n);

    // Reset during FALL aborts the pulse; first pulse afterwards needs a full period
    bus.PERIOD = 20; bus.AMPLITUDE = 12'd2000; bus.STEP = 8'd255; bus.TAU_SHIFT = 4'd4;
    bus.FORCE = 1'b1; cycle(); bus.FORCE = 1'b0;
    n = 0;
    while (m_state != M_FALL && n < 40) begin cycle(); n++; end
    cycle(); cycle();
    check("f_in_fall", bus.FAKE_ACTIVE, 1'b1);
    #2;
    RESETN = 1'b0;
    #1;
    check("f_rst_adc_out", bus.ADC_OUT, '0);
    check("f_rst_active", bus.FAKE_ACTIVE, 1'b0);
    check("f_rst_count", bus.PULSE_COUNT, 16'd0);
    model_reset();
    @(posedge CLK); #1;
    RESETN = 1'b1;
    repeat (19) cycle();
    check("f_no_early_pulse", bus.PULSE_COUNT, 16'd0);
    cycle();
    check("f_first_pulse", bus.PULSE_COUNT, 16'd1);
    check("f_first_active", bus.FAKE_ACTIVE, 1'b1);
    bus.PERIOD = 0;
    wait_active(1'b0, 400, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
